// File: rtl/div_seq.sv
// rtl/div_seq.sv - unsigned sequential divider using repeated subtraction
// Controller FSM and datapath share one registered process; outputs come straight from registers.
module div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic             rem_ge_d;
  logic [WIDTH-1:0] rem_diff_d;

  assign rem_ge_d   = (rem_q >= divisor_q);
  assign rem_diff_d = rem_q - divisor_q;

  // The dividend is parked in its own register so the previous remainder
  // stays visible until the divisor capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_A;
            busy_q  <= 1'b1;
          end
        end
        LOAD_A: begin
          dividend_q <= data_in;
          state_q    <= LOAD_B;
        end
        LOAD_B: begin
          divisor_q <= data_in;
          rem_q     <= dividend_q;
          quo_q     <= '0;
          dbz_q     <= 1'b0;
          state_q   <= CHECK;
        end
        CHECK: begin
          if (divisor_q == '0) begin
            dbz_q   <= 1'b1;
            quo_q   <= '1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= SUB;
          end
        end
        SUB: begin
          if (rem_ge_d) begin
            rem_q <= rem_diff_d;
            quo_q <= quo_q + 1'b1;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
